// File: rtl/fetch_stage_if.sv
// Instruction-memory request/valid handshake between fetch and imem.
// The fetch side issues req/addr and waits for valid with rdata.
interface fetch_stage_if;
    logic        req;
    logic [15:0] addr;
    logic [15:0] rdata;
    logic        valid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output valid
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, multi-cycle imem handshake, IF/ID write.
// Handles hazard stalls, branch redirects and HLT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [15:0]         redirect_pc,
    fetch_stage_if.master       imem,
    output logic [15:0]         ifid_instr,
    output logic [15:0]         ifid_pc_nxt,
    output logic                ifid_wen,
    output logic                ifid_flush,
    output logic                halted
);

    typedef enum logic [1:0] {
        REQ,
        HOLD,
        DROP,
        HALTED
    } state_t;

    state_t      state;
    state_t      state_d;
    logic [15:0] pc;
    logic [15:0] pc_d;
    logic [15:0] pc_inc;
    logic [15:0] hold_instr;
    logic [15:0] hold_d;
    logic [15:0] word;
    logic        deliver;
    logic        wen;
    logic        flush;

    assign pc_inc    = pc + 16'd2;
    assign imem.addr = pc;
    assign imem.req  = !rst && (state == REQ || state == DROP);
    assign halted    = !rst && (state == HALTED);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        hold_d  = hold_instr;
        word    = imem.rdata;
        deliver = 1'b0;
        wen     = 1'b0;
        flush   = 1'b1;
        unique case (state)
            REQ: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    wen     = 1'b1;
                    state_d = imem.valid ? REQ : DROP;
                end else if (stall) begin
                    if (imem.valid) begin
                        hold_d  = imem.rdata;
                        state_d = HOLD;
                    end
                end else if (imem.valid) begin
                    deliver = 1'b1;
                end else begin
                    wen = 1'b1;
                end
            end
            HOLD: begin
                word = hold_instr;
                if (redirect) begin
                    pc_d    = redirect_pc;
                    wen     = 1'b1;
                    state_d = REQ;
                end else if (!stall) begin
                    deliver = 1'b1;
                end
            end
            DROP: begin
                // stale word is thrown away; redirect keeps waiting on it
                wen = redirect || !stall;
                if (redirect) pc_d = redirect_pc;
                if (imem.valid) state_d = REQ;
            end
            HALTED: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    wen     = 1'b1;
                    state_d = REQ;
                end
            end
            default: state_d = REQ;
        endcase
        if (rst) begin
            deliver = 1'b0;
            wen     = 1'b0;
            flush   = 1'b1;
        end
        if (deliver) begin
            wen     = 1'b1;
            flush   = 1'b0;
            pc_d    = pc_inc;
            state_d = (word[15:12] == HALT_OPCODE) ? HALTED : REQ;
        end
    end

    assign ifid_wen    = wen;
    assign ifid_flush  = flush;
    assign ifid_instr  = deliver ? word : 16'h0000;
    assign ifid_pc_nxt = deliver ? pc_inc : 16'h0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            hold_instr <= 16'h0000;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            hold_instr <= hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: handshake latency, stall, redirect,
// HLT, PC wrap and mid-wait reset, checked with immediate assertions.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_nxt;
    logic        ifid_wen;
    logic        ifid_flush;
    logic        halted;
    int          errors = 0;
    int          checks = 0;

    fetch_stage_if imem ();

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .ifid_instr  (ifid_instr),
        .ifid_pc_nxt (ifid_pc_nxt),
        .ifid_wen    (ifid_wen),
        .ifid_flush  (ifid_flush),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // inputs change 1 ns after the edge; outputs sampled 1 ns later
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        imem.valid = v;
        imem.rdata = d;
        #1;
    endtask

    task automatic bubble(input string tag);
        chk({tag, "_wen"}, {15'd0, ifid_wen}, 16'd1);
        chk({tag, "_flush"}, {15'd0, ifid_flush}, 16'd1);
    endtask

    task automatic got(input string tag, input logic [15:0] ins,
                       input logic [15:0] nxt);
        chk({tag, "_instr"}, ifid_instr, ins);
        chk({tag, "_pcnxt"}, ifid_pc_nxt, nxt);
        chk({tag, "_wen"}, {15'd0, ifid_wen}, 16'd1);
        chk({tag, "_flush"}, {15'd0, ifid_flush}, 16'd0);
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        imem.valid = 1'b0;
        imem.rdata = 16'h0000;
        tick();
        #1;
        chk("rst_req", {15'd0, imem.req}, 16'd0);
        chk("rst_wen", {15'd0, ifid_wen}, 16'd0);
        chk("rst_flush", {15'd0, ifid_flush}, 16'd1);
        chk("rst_instr", ifid_instr, 16'h0000);
        chk("rst_halted", {15'd0, halted}, 16'd0);
        tick();
        rst = 1'b0;

        // zero-wait memory
        drive(1'b1, 16'h1234);
        chk("t1_addr0", imem.addr, 16'h0000);
        chk("t1_req", {15'd0, imem.req}, 16'd1);
        got("t1_w0", 16'h1234, 16'h0002);
        tick();
        drive(1'b1, 16'h5678);
        chk("t1_addr2", imem.addr, 16'h0002);
        got("t1_w1", 16'h5678, 16'h0004);
        tick();
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        drive(1'b1, 16'h9999);
        chk("t1_addr4", imem.addr, 16'h0004);
        bubble("t1_redir");
        tick();
        redirect = 1'b0;

        // 3-cycle latency at 0x0010
        drive(1'b0, 16'h0000);
        chk("t2_addr", imem.addr, 16'h0010);
        chk("t2_req0", {15'd0, imem.req}, 16'd1);
        bubble("t2_b0");
        tick();
        drive(1'b0, 16'h0000);
        chk("t2_req1", {15'd0, imem.req}, 16'd1);
        bubble("t2_b1");
        tick();
        drive(1'b1, 16'h1111);
        got("t2_w", 16'h1111, 16'h0012);
        tick();

        // stall while the word returns
        stall = 1'b1;
        drive(1'b1, 16'hABCD);
        chk("t3_wen0", {15'd0, ifid_wen}, 16'd0);
        tick();
        drive(1'b0, 16'h0000);
        chk("t3_wen1", {15'd0, ifid_wen}, 16'd0);
        chk("t3_noreq", {15'd0, imem.req}, 16'd0);
        tick();
        stall = 1'b0;
        drive(1'b0, 16'h0000);
        chk("t3_noreq2", {15'd0, imem.req}, 16'd0);
        got("t3_hold", 16'hABCD, 16'h0014);
        tick();

        // redirect over an outstanding access to 0x0020
        redirect = 1'b1;
        redirect_pc = 16'h0020;
        drive(1'b1, 16'h7777);
        tick();
        redirect_pc = 16'h0100;
        drive(1'b0, 16'h0000);
        chk("t4_addr", imem.addr, 16'h0020);
        bubble("t4_redir");
        tick();
        redirect = 1'b0;
        drive(1'b1, 16'hDEAD);
        chk("t4_drop_req", {15'd0, imem.req}, 16'd1);
        bubble("t4_drop");
        tick();
        drive(1'b1, 16'h2222);
        chk("t4_addr2", imem.addr, 16'h0100);
        got("t4_w", 16'h2222, 16'h0102);
        tick();

        // HLT at 0x0040
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        drive(1'b1, 16'h5555);
        tick();
        redirect = 1'b0;
        drive(1'b1, 16'hF000);
        chk("t5_addr", imem.addr, 16'h0040);
        got("t5_hlt", 16'hF000, 16'h0042);
        tick();
        drive(1'b0, 16'h0000);
        chk("t5_halted", {15'd0, halted}, 16'd1);
        chk("t5_req", {15'd0, imem.req}, 16'd0);
        chk("t5_wen", {15'd0, ifid_wen}, 16'd0);
        tick();
        redirect = 1'b1;
        redirect_pc = 16'h0000;
        drive(1'b0, 16'h0000);
        bubble("t5_resume");
        tick();
        redirect = 1'b0;
        drive(1'b1, 16'h3333);
        chk("t5_unhalt", {15'd0, halted}, 16'd0);
        chk("t5_addr0", imem.addr, 16'h0000);
        got("t5_w", 16'h3333, 16'h0002);
        tick();

        // PC wrap
        redirect = 1'b1;
        redirect_pc = 16'hFFFE;
        drive(1'b1, 16'h6666);
        tick();
        redirect = 1'b0;
        drive(1'b1, 16'h0000);
        chk("t6_addr", imem.addr, 16'hFFFE);
        got("t6_wrap", 16'h0000, 16'h0000);
        tick();
        drive(1'b1, 16'h4444);
        chk("t6_addr0", imem.addr, 16'h0000);
        got("t6_w", 16'h4444, 16'h0002);
        tick();

        // reset while waiting on memory at 0x0002
        drive(1'b0, 16'h0000);
        chk("t6_wait_addr", imem.addr, 16'h0002);
        bubble("t6_wait");
        rst = 1'b1;
        #1;
        chk("t6_rst_req", {15'd0, imem.req}, 16'd0);
        chk("t6_rst_wen", {15'd0, ifid_wen}, 16'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0000);
        chk("t6_rst_pc", imem.addr, 16'h0000);
        chk("t6_rst_req1", {15'd0, imem.req}, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
